synapse_delay_array: RTL and testbench

Multi-channel, parametrised successor to the single-channel fixed-delay synapse. It sits between presynaptic neuron spike outputs and a postsynaptic neuron. Each of N_CH channels delays incoming spikes by a programmable 1..MAX_DELAY cycles and is fully pipelined, so every cycle can carry a new spike. Each channel carries a programmable weight; the block outputs a per-cycle postsynaptic current (psc) equal to the summed weights of the channels emitting this cycle.

---
 rtl/synapse_delay_array.sv | 107 ++++++++++
 tb/tb_synapse_delay_array.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/synapse_delay_array.sv
// Multi-channel programmable-delay synapse: each channel delays spikes by 1..MAX_DELAY
// cycles and the block sums the weights of channels firing this cycle into psc.

module synapse_delay_ch #(
  parameter int MAX_DELAY = 15,
  parameter int DW        = 4,
  parameter int WW        = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          spike,
  input  logic          wr,
  input  logic [DW-1:0] wr_delay,
  input  logic [WW-1:0] wr_weight,
  input  logic          wr_en,
  output logic          spike_out,
  output logic          spike_nxt,
  output logic [WW-1:0] weight
);
  logic [DW-1:0]        delay, tap;
  logic                 en, cap;
  logic [MAX_DELAY-1:0] line;

  // A spike captured at edge k sits in line[j] after edge k+j, so tapping
  // line[delay-1] into the output register emits it at edge k+delay.
  assign tap       = delay - DW'(1);
  assign cap       = spike & (wr ? wr_en : en);
  assign spike_nxt = ~wr & line[tap];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      delay     <= DW'(1);
      weight    <= WW'(1);
      en        <= 1'b1;
      line      <= '0;
      spike_out <= 1'b0;
    end else begin
      spike_out <= spike_nxt;
      if (wr) begin
        delay  <= wr_delay;
        weight <= wr_weight;
        en     <= wr_en;
        line   <= MAX_DELAY'(cap);
      end else begin
        line   <= (line << 1) | MAX_DELAY'(cap);
      end
    end
  end
endmodule

module synapse_delay_array #(
  parameter int N_CH      = 4,
  parameter int MAX_DELAY = 15,
  parameter int WW        = 4,
  parameter int DW        = $clog2(MAX_DELAY + 1),
  parameter int CW        = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int PW        = WW + $clog2(N_CH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] spike_in,
  input  logic            cfg_we,
  input  logic [CW-1:0]   cfg_ch,
  input  logic [DW-1:0]   cfg_delay,
  input  logic [WW-1:0]   cfg_weight,
  input  logic            cfg_en,
  output logic [N_CH-1:0] spike_out,
  output logic [PW-1:0]   psc
);
  logic [N_CH-1:0]         spike_nxt;
  logic [N_CH-1:0][WW-1:0] weight;
  logic [DW-1:0]           dsat;
  logic [PW-1:0]           psc_nxt;

  always_comb begin
    dsat = cfg_delay;
    if (cfg_delay == '0)                 dsat = DW'(1);
    else if (int'(cfg_delay) > MAX_DELAY) dsat = DW'(MAX_DELAY);
  end

  // Out-of-range channel indices match no lane, so such writes are dropped.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    synapse_delay_ch #(.MAX_DELAY(MAX_DELAY), .DW(DW), .WW(WW)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .spike     (spike_in[c]),
      .wr        (cfg_we && (int'(cfg_ch) == c)),
      .wr_delay  (dsat),
      .wr_weight (cfg_weight),
      .wr_en     (cfg_en),
      .spike_out (spike_out[c]),
      .spike_nxt (spike_nxt[c]),
      .weight    (weight[c])
    );
  end

  always_comb begin
    psc_nxt = '0;
    for (int c = 0; c < N_CH; c++)
      if (spike_nxt[c]) psc_nxt = psc_nxt + PW'(weight[c]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) psc <= '0;
    else       psc <= psc_nxt;
  end
endmodule

// File: tb/tb_synapse_delay_array.sv
// Scoreboard bench for synapse_delay_array: expected pulses are queued at capture
// time and retired on the cycle they are due.

module tb_synapse_delay_array;
  localparam int N_CH = 4, MAX_DELAY = 15, WW = 4, DW = 4, CW = 2, PW = 7;

  logic            clk = 1'b0, reset;
  logic [N_CH-1:0] spike_in, spike_out;
  logic            cfg_we, cfg_en;
  logic [CW-1:0]   cfg_ch;
  logic [DW-1:0]   cfg_delay;
  logic [WW-1:0]   cfg_weight;
  logic [PW-1:0]   psc;
  logic [2:0]      spike_in3, spike_out3;
  logic [6:0]      psc3;

  typedef struct { int t; int ch; } ev_t;
  ev_t sb[$];
  int  m_dly[N_CH], m_w[N_CH];
  bit  m_en[N_CH];
  int  cyc = 0, n_cmp = 0, n_err = 0;
  logic [N_CH-1:0] eso;
  int  epsc;

  always #5 clk = ~clk;

  synapse_delay_array #(.N_CH(N_CH), .MAX_DELAY(MAX_DELAY), .WW(WW)) u_dut (
    .clk(clk), .reset(reset), .spike_in(spike_in), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_delay(cfg_delay), .cfg_weight(cfg_weight), .cfg_en(cfg_en),
    .spike_out(spike_out), .psc(psc));

  synapse_delay_array #(.N_CH(3), .MAX_DELAY(MAX_DELAY), .WW(WW)) u_dut3 (
    .clk(clk), .reset(reset), .spike_in(spike_in3), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_delay(cfg_delay), .cfg_weight(cfg_weight), .cfg_en(cfg_en),
    .spike_out(spike_out3), .psc(psc3));

  task automatic model_reset();
    sb.delete();
    for (int c = 0; c < N_CH; c++) begin m_dly[c] = 1; m_w[c] = 1; m_en[c] = 1'b1; end
  endtask

  // Drive one cycle of stimulus, update the model at the edge, return what is due now.
  task automatic tick(input logic [N_CH-1:0] spk, input logic we, input int ch, input int d,
                      input int w, input logic en, output logic [N_CH-1:0] xso, output int xpsc);
    @(negedge clk);
    spike_in = spk; cfg_we = we; cfg_ch = CW'(ch); cfg_delay = DW'(d);
    cfg_weight = WW'(w); cfg_en = en;
    @(posedge clk);
    cyc++;
    if (we && ch < N_CH) begin
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].ch == ch) sb.delete(i);
      m_dly[ch] = (d == 0) ? 1 : (d > MAX_DELAY) ? MAX_DELAY : d;
      m_w[ch] = w; m_en[ch] = en;
    end
    xso = '0; xpsc = 0;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].t == cyc) begin
        xso[sb[i].ch] = 1'b1; xpsc += m_w[sb[i].ch]; sb.delete(i);
      end
    for (int c = 0; c < N_CH; c++)
      if (spk[c] && m_en[c]) sb.push_back('{cyc + m_dly[c], c});
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; spike_in = '0; spike_in3 = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_delay = '0; cfg_weight = '0; cfg_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); spike_in = N_CH'($urandom); spike_in3 = 3'($urandom);
      @(posedge clk); #1;
      n_cmp += 2;
      if (spike_out !== '0) begin n_err++; $display("FAIL reset_spike_out got=%b want=0", spike_out); end
      if (psc !== '0) begin n_err++; $display("FAIL reset_psc got=%0d want=0", psc); end
    end
    @(negedge clk); reset = 1'b0; spike_in = '0; spike_in3 = '0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick((i == 0) ? N_CH'(1) : '0, 1'b0, 0, 0, 0, 1'b0, eso, epsc);
      n_cmp += 2;
      if (spike_out !== eso) begin n_err++; $display("FAIL post_reset_spike got=%b want=%b", spike_out, eso); end
      if (psc !== PW'(epsc)) begin n_err++; $display("FAIL post_reset_psc got=%0d want=%0d", psc, epsc); end
    end
  endtask

  task automatic test_delay3();
    for (int i = 0; i < 8; i++) begin
      tick((i == 1) ? N_CH'(4) : '0, i == 0, 2, 3, 5, 1'b1, eso, epsc);
      n_cmp += 2;
      if (spike_out !== eso) begin n_err++; $display("FAIL delay3_spike cyc=%0d got=%b want=%b", cyc, spike_out, eso); end
      if (psc !== PW'(epsc)) begin n_err++; $display("FAIL delay3_psc cyc=%0d got=%0d want=%0d", cyc, psc, epsc); end
    end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL delay3_drain got=%0d pending want=0", sb.size()); end
  endtask

  task automatic test_max_delay();
    for (int i = 0; i < 28; i++) begin
      tick((i >= 1 && i <= 8) ? N_CH'(2) : '0, i == 0, 1, MAX_DELAY, 1, 1'b1, eso, epsc);
      n_cmp += 2;
      if (spike_out !== eso) begin n_err++; $display("FAIL maxdly_spike cyc=%0d got=%b want=%b", cyc, spike_out, eso); end
      if (psc !== PW'(epsc)) begin n_err++; $display("FAIL maxdly_psc cyc=%0d got=%0d want=%0d", cyc, psc, epsc); end
    end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL maxdly_drain got=%0d pending want=0", sb.size()); end
  endtask

  task automatic test_all_weights();
    for (int i = 0; i < 8; i++) begin
      tick((i == 4) ? '1 : '0, i < 4, i, 2, i + 1, 1'b1, eso, epsc);
      n_cmp += 2;
      if (spike_out !== eso) begin n_err++; $display("FAIL allw_spike cyc=%0d got=%b want=%b", cyc, spike_out, eso); end
      if (psc !== PW'(epsc)) begin n_err++; $display("FAIL allw_psc cyc=%0d got=%0d want=%0d", cyc, psc, epsc); end
      if (i == 6) begin
        n_cmp++;
        if (psc !== PW'(10)) begin n_err++; $display("FAIL allw_sum got=%0d want=10", psc); end
      end
    end
  endtask

  task automatic test_reconfig();
    // step: {spike mask, we, ch, delay, weight, en}
    logic [N_CH-1:0] spk[14] = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                                 4'h0, 4'h1, 4'h0, 4'h2, 4'h0};
    bit we[14]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
    int ch[14]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int dl[14]  = '{5, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    bit en[14]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    for (int i = 0; i < 14; i++) begin
      tick(spk[i], we[i], ch[i], dl[i], 2, en[i], eso, epsc);
      n_cmp += 2;
      if (spike_out !== eso) begin n_err++; $display("FAIL reconf_spike cyc=%0d got=%b want=%b", cyc, spike_out, eso); end
      if (psc !== PW'(epsc)) begin n_err++; $display("FAIL reconf_psc cyc=%0d got=%0d want=%0d", cyc, psc, epsc); end
    end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL reconf_drain got=%0d pending want=0", sb.size()); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) begin
      tick((i == 4 || i == 5) ? '1 : '0, i < 4, i, 3, i + 1, 1'b1, eso, epsc);
      n_cmp += 2;
      if (spike_out !== eso) begin n_err++; $display("FAIL arst_pre_spike cyc=%0d got=%b want=%b", cyc, spike_out, eso); end
      if (psc !== PW'(epsc)) begin n_err++; $display("FAIL arst_pre_psc cyc=%0d got=%0d want=%0d", cyc, psc, epsc); end
    end
    #1 reset = 1'b1;
    #1;
    n_cmp += 2;
    if (spike_out !== '0) begin n_err++; $display("FAIL arst_spike got=%b want=0", spike_out); end
    if (psc !== '0) begin n_err++; $display("FAIL arst_psc got=%0d want=0", psc); end
    @(negedge clk); reset = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      tick((i == 2) ? '1 : '0, 1'b0, 0, 0, 0, 1'b0, eso, epsc);
      n_cmp += 2;
      if (spike_out !== eso) begin n_err++; $display("FAIL arst_post_spike cyc=%0d got=%b want=%b", cyc, spike_out, eso); end
      if (psc !== PW'(epsc)) begin n_err++; $display("FAIL arst_post_psc cyc=%0d got=%0d want=%0d", cyc, psc, epsc); end
    end
  endtask

  task automatic test_ignore_oob();
    // cfg_ch = 3 is out of range for the 3-channel instance and must leave it at defaults.
    tick('0, 1'b1, 3, 5, 9, 1'b0, eso, epsc);
    spike_in3 = 3'b111;
    tick('0, 1'b0, 0, 0, 0, 1'b0, eso, epsc);
    spike_in3 = 3'b000;
    tick('0, 1'b0, 0, 0, 0, 1'b0, eso, epsc);
    n_cmp += 2;
    if (spike_out3 !== 3'b111) begin n_err++; $display("FAIL oob_spike got=%b want=111", spike_out3); end
    if (psc3 !== 7'd3) begin n_err++; $display("FAIL oob_psc got=%0d want=3", psc3); end
    tick('0, 1'b0, 0, 0, 0, 1'b0, eso, epsc);
    n_cmp++;
    if (spike_out3 !== 3'b000) begin n_err++; $display("FAIL oob_single got=%b want=000", spike_out3); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_delay3();
    test_max_delay();
    test_all_weights();
    test_reconfig();
    test_async_reset();
    test_ignore_oob();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
